result_requant_buffer: RTL and testbench

//  Downstream stage of top_accel: consumes the N*N signed ACC_W result stream from its m_axis port.

---
 rtl/result_requant_buffer_pkg.sv | 50 +++++
 rtl/result_requant_buffer_if.sv | 18 +
 rtl/result_requant_buffer_sync_fifo.sv | 62 ++++++
 rtl/result_requant_buffer.sv | 106 ++++++++++
 tb/tb_result_requant_buffer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_requant_buffer_pkg.sv
// Shared types and helpers for the result requantisation buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   Holds default widths, saturation limits, the stored beat layout and
//   the round/shift/saturate function used on the FIFO write path.
package result_requant_buffer_pkg;

    localparam int ACC_W      = 32;
    localparam int OUT_W      = 16;
    localparam int N_DIM      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int SHIFT_W    = 5;

    localparam int SAT_MAX = (2 ** (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (OUT_W - 1));

    // Limits widened to the ACC_W+1 intermediate so comparisons stay signed.
    localparam logic signed [ACC_W:0] SAT_MAX_W = (ACC_W + 1)'(SAT_MAX);
    localparam logic signed [ACC_W:0] SAT_MIN_W = (ACC_W + 1)'(SAT_MIN);

    typedef struct packed {
        logic                    last;
        logic signed [OUT_W-1:0] data;
    } res_beat_t;

    // Round-half-up, arithmetic right shift, saturate to OUT_W.
    // One extra bit of headroom keeps acc + half from wrapping for any acc.
    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [ACC_W-1:0] acc,
        input logic [SHIFT_W-1:0]      sh
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] v;
        ext  = {acc[ACC_W-1], acc};
        half = '0;
        // half stays zero for sh==0, so the shift path degenerates to a pass-through
        if (sh != '0) begin
            half[sh - 1'b1] = 1'b1;
        end
        v = (ext + half) >>> sh;
        if (v > SAT_MAX_W) begin
            return OUT_W'(SAT_MAX);
        end else if (v < SAT_MIN_W) begin
            return OUT_W'(SAT_MIN);
        end
        return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/result_requant_buffer_if.sv
// Stream bundle (valid/ready/data/last) parameterised by data width.
// Latency: n/a (wires only).
// Backpressure: tready flows slave -> master; tvalid/tdata/tlast flow master -> slave.
//   master: drives tvalid, tdata, tlast; samples tready.
//   slave : samples tvalid, tdata, tlast; drives tready.
interface result_requant_buffer_if
    import result_requant_buffer_pkg::*;
#(
    parameter int W = ACC_W
);
    logic         tvalid;
    logic [W-1:0] tdata;
    logic         tlast;
    logic         tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/result_requant_buffer_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and occupancy count.
// Latency: a write at edge t is readable at rd_dat after edge t.
// Backpressure: writes ignored when full, reads ignored when empty; no pass-through.
//   Ports: clk, rst_n (sync, active low), wr_en/wr_dat, rd_en/rd_dat,
//          full, empty, level (0..DEPTH).
module result_requant_buffer_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                  wr_ptr_q, wr_ptr_d;
    logic [AW:0]                  rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
    logic                         do_wr;
    logic                         do_rd;

    // Same index with opposite wrap bits means the writer lapped the reader.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level  = wr_ptr_q - rd_ptr_q;
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage is cleared on reset so the head reads zero until the first write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/result_requant_buffer.sv
// Requantises the ACC_W result stream to OUT_W, buffers it, regenerates TLAST.
// Latency: one cycle from s_axis handshake to m_axis valid (empty FIFO).
// Backpressure: s_axis.tready = !full; m_axis.tready stalls the FIFO head.
//   Ports: clk, rst_n (sync, active low), cfg_shift (latched per frame),
//          s_axis (ACC_W in), m_axis (OUT_W out), frame_done pulse,
//          sticky tlast_err with clear_err, level = FIFO occupancy.
module result_requant_buffer
    import result_requant_buffer_pkg::*;
#(
    parameter int N     = N_DIM,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    result_requant_buffer_if.slave  s_axis,
    result_requant_buffer_if.master m_axis,
    output logic                    frame_done,
    output logic                    tlast_err,
    input  logic                    clear_err,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int CNT_W = $clog2(N * N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N * N - 1);

    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               tlast_err_q, tlast_err_d;
    logic               frame_done_q, frame_done_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               wr_fire;
    logic               rd_fire;
    logic               tlast_out;
    logic [SHIFT_W-1:0] eff_shift;
    res_beat_t          wr_beat;
    res_beat_t          head_beat;

    result_requant_buffer_sync_fifo #(
        .WIDTH ($bits(res_beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_fire),
        .wr_dat (wr_beat),
        .rd_en  (rd_fire),
        .rd_dat (head_beat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign s_axis.tready = !fifo_full;
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = head_beat.data;
    assign m_axis.tlast  = head_beat.last;
    assign frame_done    = frame_done_q;
    assign tlast_err     = tlast_err_q;

    always_comb begin
        wr_fire      = s_axis.tvalid && !fifo_full;
        rd_fire      = !fifo_empty && m_axis.tready;
        tlast_out    = (in_cnt_q == LAST_IDX);
        // The first beat of a frame uses the live cfg_shift; the rest use the latch,
        // so a mid-frame cfg change cannot split one frame across two scales.
        eff_shift    = (in_cnt_q == '0) ? cfg_shift : shift_q;
        wr_beat.last = tlast_out;
        wr_beat.data = requant($signed(s_axis.tdata), eff_shift);

        in_cnt_d     = in_cnt_q;
        shift_d      = shift_q;
        tlast_err_d  = tlast_err_q;
        frame_done_d = rd_fire && head_beat.last;

        if (wr_fire) begin
            in_cnt_d = tlast_out ? '0 : in_cnt_q + 1'b1;
            if (in_cnt_q == '0) begin
                shift_d = cfg_shift;
            end
            // Upstream TLAST is only audited; the local count stays authoritative.
            if (s_axis.tlast != tlast_out) begin
                tlast_err_d = 1'b1;
            end
        end
        if (clear_err) begin
            tlast_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt_q     <= '0;
            shift_q      <= '0;
            tlast_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            shift_q      <= shift_d;
            tlast_err_q  <= tlast_err_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_result_requant_buffer.sv
module tb_result_requant_buffer;
    import result_requant_buffer_pkg::*;

    localparam int FRAME = N_DIM * N_DIM;

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic [SHIFT_W-1:0]              cfg_shift = '0;
    logic                            clear_err = 1'b0;
    logic                            frame_done;
    logic                            tlast_err;
    logic [$clog2(FIFO_DEPTH):0]     level;

    result_requant_buffer_if #(.W(ACC_W)) s_if ();
    result_requant_buffer_if #(.W(OUT_W)) m_if ();

    result_requant_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_shift  (cfg_shift),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .frame_done (frame_done),
        .tlast_err  (tlast_err),
        .clear_err  (clear_err),
        .level      (level)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- reference model ----------------
    res_beat_t sb[$];
    int        mdl_cnt   = 0;
    int        mdl_shift = 0;
    bit        mdl_err   = 1'b0;

    // floor((acc + 2^(sh-1)) / 2^sh), then clamp
    function automatic longint ref_requant(input longint acc, input int sh);
        longint d, num, q;
        if (sh == 0) begin
            q = acc;
        end else begin
            d = 1;
            repeat (sh) d = d * 2;
            num = acc + d / 2;
            q = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
        end
        if (q > SAT_MAX) q = SAT_MAX;
        if (q < SAT_MIN) q = SAT_MIN;
        return q;
    endfunction

    task automatic model_accept(input logic [ACC_W-1:0] dat, input bit last_in);
        res_beat_t e;
        if (mdl_cnt == 0) mdl_shift = int'(cfg_shift);
        e.last = (mdl_cnt == FRAME - 1);
        e.data = OUT_W'(ref_requant(longint'($signed(dat)), mdl_shift));
        if (last_in != e.last) mdl_err = 1'b1;
        sb.push_back(e);
        mdl_cnt = (mdl_cnt + 1) % FRAME;
    endtask

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ACC_W-1:0] dat, input bit last);
        bit rdy;
        int waitc;
        waitc = 0;
        rdy = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = dat;
        s_if.tlast  = last;
        forever begin
            @(negedge clk);
            rdy = s_if.tready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waitc++;
            if (waitc > 500) begin
                timeout_fail("send_timeout");
                break;
            end
        end
        if (rdy) model_accept(dat, last);
        s_if.tvalid = 1'b0;
    endtask

    function automatic logic [ACC_W-1:0] rnd_data();
        if ($urandom_range(0, 1) == 0) return ACC_W'($urandom);
        return ACC_W'(int'($urandom_range(0, 200000)) - 100000);
    endfunction

    task automatic finish_frame();
        while (mdl_cnt != 0) send(rnd_data(), mdl_cnt == FRAME - 1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((sb.size() != 0 || level != 0) && c < 400) begin
            cyc(1);
            c++;
        end
        if (c >= 400) timeout_fail("drain_timeout");
        cyc(3);
    endtask

    // ---------------- downstream ready ----------------
    int rdy_mode = 0;  // 0 stall, 1 always ready, 2 random
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int fd_cnt = 0;
    bit fd_pend = 1'b0;
    initial begin
        res_beat_t exp_b;
        forever begin
            @(negedge clk);
            if (fd_pend || frame_done) check("frame_done", frame_done, fd_pend);
            if (frame_done) fd_cnt++;
            fd_pend = 1'b0;
            if (rst_n && m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL out_unexpected: got data %0d with nothing expected", $signed(m_if.tdata));
                end else begin
                    exp_b = sb.pop_front();
                    check("out_data", $signed(m_if.tdata), exp_b.data);
                    check("out_last", m_if.tlast, exp_b.last);
                end
                fd_pend = m_if.tlast;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        check("rst_s_tready", s_if.tready, 1);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_tlast_err", tlast_err, 0);
        check("rst_level", level, 0);

        // 1: counting stream, shift 0
        rdy_mode = 1;
        cfg_shift = 0;
        cyc(2);
        fd_cnt = 0;
        for (int i = 1; i <= FRAME; i++) send(ACC_W'(i), i == FRAME);
        drain();
        check("t1_frame_done_cnt", fd_cnt, 1);
        check("t1_tlast_err", tlast_err, 0);

        // 2: saturation at shift 0
        send(ACC_W'(70000), 1'b0);
        send(ACC_W'(-70000), 1'b0);
        send(ACC_W'(32767), 1'b0);
        finish_frame();

        // 3: rounding at shift 2
        cfg_shift = 2;
        send(ACC_W'(10), 1'b0);
        send(ACC_W'(-10), 1'b0);
        send(ACC_W'(6), 1'b0);
        send(ACC_W'(2), 1'b0);
        finish_frame();
        drain();

        // 4: cfg change mid-frame is deferred to the next frame
        cfg_shift = 2;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 5) cfg_shift = 0;
            send(ACC_W'(int'($urandom_range(0, 4000)) - 2000), i == FRAME - 1);
        end
        for (int i = 0; i < FRAME; i++) send(ACC_W'(int'($urandom_range(0, 4000)) - 2000), i == FRAME - 1);
        drain();
        check("t4_tlast_err", tlast_err, mdl_err);

        // 5: full FIFO backpressure
        rdy_mode = 0;
        cyc(2);
        fork
            begin
                for (int i = 0; i < 10; i++) send(rnd_data(), mdl_cnt == FRAME - 1);
            end
        join_none
        cyc(25);
        check("t5_level_full", level, FIFO_DEPTH);
        check("t5_s_tready", s_if.tready, 0);
        check("t5_m_tvalid", m_if.tvalid, 1);
        rdy_mode = 1;
        wait fork;
        drain();
        check("t5_s_tready_after", s_if.tready, 1);
        finish_frame();
        drain();

        // 6: early upstream tlast
        for (int i = 0; i < FRAME; i++) begin
            send(rnd_data(), i == 3);
            if (i == 3) check("t6_err_set", tlast_err, 1);
        end
        drain();
        check("t6_err_sticky", tlast_err, 1);
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
        mdl_err = 1'b0;
        check("t6_err_clear", tlast_err, 0);

        // clear wins over a simultaneous mismatch
        clear_err = 1'b1;
        send(rnd_data(), 1'b1);
        clear_err = 1'b0;
        mdl_err = 1'b0;
        check("t6_clear_priority", tlast_err, 0);
        finish_frame();
        drain();

        // reset mid-frame
        rdy_mode = 0;
        cyc(2);
        for (int i = 0; i < 5; i++) send(rnd_data(), 1'b0);
        check("t6_level_pre_rst", level, 5);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        sb.delete();
        mdl_cnt = 0;
        mdl_err = 1'b0;
        check("t6_level_post_rst", level, 0);
        check("t6_m_tvalid_post_rst", m_if.tvalid, 0);
        rdy_mode = 1;
        fd_cnt = 0;
        for (int i = 0; i < FRAME; i++) send(rnd_data(), i == FRAME - 1);
        drain();
        check("t6_err_after_rst", tlast_err, 0);
        check("t6_fd_after_rst", fd_cnt, 1);

        // random frames with random shifts, gaps and backpressure
        rdy_mode = 2;
        fd_cnt = 0;
        for (int f = 0; f < 6; f++) begin
            cfg_shift = SHIFT_W'($urandom_range(0, 31));
            for (int i = 0; i < FRAME; i++) begin
                if ($urandom_range(0, 3) == 0) cyc(1);
                if (i == 7) cfg_shift = SHIFT_W'($urandom_range(0, 31));
                send(rnd_data(), i == FRAME - 1);
            end
        end
        rdy_mode = 1;
        drain();
        check("rand_fd_cnt", fd_cnt, 6);
        check("rand_tlast_err", tlast_err, mdl_err);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
